// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped timer/counter: register offsets,
// FSM state encoding, mode encoding and CTRL bit positions.
package timer_counter_pkg;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned CTRL_W = 4;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] TC_MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] TC_MODE_PERIODIC = 2'b01;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_MODE_MSB = 2;
  localparam int unsigned CTRL_IM       = 3;

endpackage

// File: rtl/timer_counter.sv
// Down-counting timer with one-shot/periodic modes; register file and FSM in one
// block. irq feeds HWInt[0] of the CP0 exception unit.
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [CNT_W-1:0] din,
  output logic [CNT_W-1:0] dout,
  output logic             irq
);

  tc_state_e          state_q, state_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   preset_q, preset_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               flag_q, flag_d;
  logic               irq_q, irq_d;

  logic               wr_ctrl, wr_preset, en, periodic, flag_set;

  assign wr_ctrl   = we && (addr == TC_CTRL);
  assign wr_preset = we && (addr == TC_PRESET);
  assign en        = ctrl_q[CTRL_EN];
  assign periodic  = (ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB] == TC_MODE_PERIODIC);

  // Next-state: FSM first, then software writes override CTRL; a flag set beats any clear.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
    flag_set = 1'b0;

    case (state_q)
      TC_IDLE: begin
        if (en) state_d = TC_LOAD;
      end
      TC_LOAD: begin
        count_d = preset_q;
        state_d = TC_CNT;
      end
      TC_CNT: begin
        if (!en) begin
          state_d = TC_IDLE;
        end else if (count_q > CNT_W'(1)) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          count_d  = '0;
          flag_set = 1'b1;
          state_d  = TC_INT;
        end
      end
      TC_INT: begin
        if (periodic) begin
          state_d = TC_LOAD;
          flag_d  = 1'b0;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = TC_IDLE;
        end
      end
      default: state_d = TC_IDLE;
    endcase

    if (wr_ctrl) begin
      ctrl_d = din[CTRL_W-1:0];
      flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d = din;
      flag_d   = 1'b0;
    end
    if (flag_set) flag_d = 1'b1;

    irq_d = ctrl_d[CTRL_IM] & flag_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= TC_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      irq_q    <= irq_d;
    end
  end

  // Read mux; unimplemented CTRL bits and the reserved word read as zero.
  always_comb begin
    case (addr)
      TC_CTRL:   dout = CNT_W'(ctrl_q);
      TC_PRESET: dout = preset_q;
      TC_COUNT:  dout = count_q;
      default:   dout = '0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped timer/counter device on the system bridge.
- Its interrupt output drives one bit of the hardware-interrupt vector (HWInt[0]) sampled by the coprocessor-0 exception unit.
- Software programs a preset value and a control word; the block counts down and raises an interrupt in one-shot or periodic mode.

Parameters:
- CNT_W, 32, width of the PRESET and COUNT registers; also the width of din/dout.
- CTRL_W, 4, implemented CTRL bits; unimplemented bits read as 0.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- addr  in  2  word select: 0=CTRL, 1=PRESET, 2=COUNT (read-only), 3=reserved.
- we  in  1  write strobe, sampled on rising edge of clk.
- din  in  CNT_W  write data.
- dout  out  CNT_W  combinational read data for the selected register; 0 for addr 3.
- irq  out  1  interrupt request to the CP0 HWInt input.

Behaviour:
- Reset (reset=0, asynchronous):
  - CTRL=0, PRESET=0, COUNT=0, state=IDLE, int_flag=0.
  - irq=0; dout reflects the zeroed registers.
  - If reset asserts mid-count, the count is abandoned; nothing resumes after release.
- CTRL fields:
  - [0] EN.
  - [2:1] MODE: 00 one-shot; 01 periodic; 10 and 11 behave as 00.
  - [3] IM, interrupt mask.
- Register writes (we=1):
  - addr 0: CTRL <= din[CTRL_W-1:0].
  - addr 1: PRESET <= din.
  - addr 2 and addr 3: writes are ignored.
  - Any write to CTRL or PRESET clears int_flag.
  - A PRESET write during CNT does not affect COUNT until the next LOAD.
- States: IDLE, LOAD, CNT, INT.
  - IDLE:
    - EN=1 -> LOAD.
    - Otherwise stay; COUNT holds.
  - LOAD:
    - COUNT <= PRESET.
    - -> CNT.
  - CNT:
    - EN=0 -> IDLE; COUNT holds.
    - Else if COUNT > 1: COUNT <= COUNT-1.
    - Else (COUNT is 1 or 0): COUNT <= 0, int_flag <= 1, -> INT.
  - INT:
    - MODE one-shot: EN <= 0, -> IDLE.
    - MODE periodic: -> LOAD; EN unchanged.
- Interrupt flag behaviour:
  - One-shot: int_flag stays set until a CTRL or PRESET write.
  - Periodic: int_flag is cleared on leaving INT, giving a 1-cycle pulse.
- irq = IM & int_flag, registered-state derived with no combinational path from din.
- Latency:
  - The edge that writes EN=1 is E0.
  - LOAD occurs at E1 and COUNT=PRESET at E2.
  - With PRESET=N>=1, irq rises after edge E(N+2).
  - Periodic period is N+2 cycles.
  - PRESET=0 behaves as PRESET=1 (interrupt one cycle after LOAD).
- Simultaneous events:
  - A CTRL write in the same cycle as the INT-state EN clear: the software write wins.
  - A CTRL/PRESET write in the same cycle int_flag would set: the set wins, so no interrupt is lost.
- No wrap-around: COUNT never decrements below 0.

Decomposition:
- Shared package (alongside the CP0 address/ExcCode constants) holds:
  - Register offsets: TC_CTRL, TC_PRESET, TC_COUNT.
  - State encoding: TC_IDLE, TC_LOAD, TC_CNT, TC_INT.
  - Mode encoding: TC_MODE_ONESHOT, TC_MODE_PERIODIC.
  - CTRL bit positions: EN, MODE, IM.
- Single module; no sub-module is warranted. Register file and FSM live in one file.

Test Plan:
- Reset: drive reset=0 mid-count with PRESET=10 -> irq=0, COUNT=0, CTRL=0 immediately; after release, COUNT stays 0 with no activity.
- One-shot count: write PRESET=5, then CTRL=0x9 (EN, one-shot, IM) at E0.
  - irq rises after E7 and stays 1.
  - CTRL reads 0x8 (EN cleared).
  - A subsequent CTRL write of 0x8 drops irq the next cycle.
- Periodic count: PRESET=3, CTRL=0xB.
  - irq is 1-cycle pulses every 5 cycles.
  - COUNT reads 3,2,1,0 in sequence each period.
- Mask: PRESET=2, CTRL=0x1 -> int_flag sets but irq stays 0; a write of CTRL=0x8 clears the flag, so irq stays 0.
- Pause and boundary:
  - Clearing EN mid-count at COUNT=4 holds COUNT=4 in IDLE.
  - Re-enabling goes through LOAD and reloads PRESET.
  - PRESET=0 gives irq 3 cycles after the enable write edge.
- Register access:
  - Write to addr 2 leaves COUNT unchanged.
  - Read of addr 3 returns 0.
  - PRESET write during CNT takes effect only at the next LOAD.
